// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the MIPS fetch stage and its F/D register.
package fetch_stage_pkg;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] PC_HANDLER = 32'h0000_4180;
   localparam logic [31:0] IM_LO_ADDR = 32'h0000_3000;
   localparam logic [31:0] IM_HI_ADDR = 32'h0000_6FFF;

   localparam int EXCCODE_SIZE = 5;
   localparam logic [EXCCODE_SIZE-1:0] EXCCODE_NONE = 5'd0;
   localparam logic [EXCCODE_SIZE-1:0] EXCCODE_ADEL = 5'd4;

   typedef enum logic [1:0] {
      FdHold   = 2'd0,
      FdLoad   = 2'd1,
      FdBubble = 2'd2
   } fd_ctl_e;

   // Misaligned or outside the instruction memory window.
   function automatic logic fetch_fault(input logic [31:0] pc,
                                        input logic [31:0] lo,
                                        input logic [31:0] hi);
      return (pc[1:0] != 2'b00) || (pc < lo) || (pc > hi);
   endfunction

endpackage

// File: rtl/fetch_stage_fd_reg.sv
// F/D pipeline register: loads the current fetch, holds on stall, or inserts a bubble.
module fd_reg
   import fetch_stage_pkg::*;
(
   input  logic                    clk,
   input  logic                    reset,
   input  logic [1:0]              ctl,
   input  logic [31:0]             load_instr,
   input  logic [31:0]             load_pc,
   input  logic [EXCCODE_SIZE-1:0] load_exccode,
   input  logic                    load_bd,
   input  logic [31:0]             bubble_pc,
   output logic [31:0]             d_instr,
   output logic [31:0]             d_pc,
   output logic [EXCCODE_SIZE-1:0] d_exccode,
   output logic                    d_bd
);

   always_ff @(posedge clk) begin
      if (reset) begin
         d_instr   <= '0;
         d_pc      <= '0;
         d_exccode <= EXCCODE_NONE;
         d_bd      <= 1'b0;
      end else begin
         case (ctl)
            FdLoad: begin
               d_instr   <= load_instr;
               d_pc      <= load_pc;
               d_exccode <= load_exccode;
               d_bd      <= load_bd;
            end
            FdBubble: begin
               d_instr   <= '0;
               d_pc      <= bubble_pc;
               d_exccode <= EXCCODE_NONE;
               d_bd      <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/fetch_stage.sv
// MIPS F stage: PC register, next-PC selection, fetch address check and F/D register.
module fetch_stage
   import fetch_stage_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = PC_RESET,
   parameter logic [31:0] HANDLER_PC = PC_HANDLER,
   parameter logic [31:0] IM_LO      = IM_LO_ADDR,
   parameter logic [31:0] IM_HI      = IM_HI_ADDR
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    stall,
   input  logic                    req,
   input  logic                    eret,
   input  logic [31:0]             epc,
   input  logic                    npc_sel,
   input  logic [31:0]             npc_target,
   input  logic                    d_is_branch,
   output logic [31:0]             imem_addr,
   input  logic [31:0]             imem_rdata,
   output logic [31:0]             d_instr,
   output logic [31:0]             d_pc,
   output logic [EXCCODE_SIZE-1:0] d_exccode,
   output logic                    d_bd
);

   logic [31:0]             pc_q;
   logic [31:0]             pc_d;
   logic                    fault;
   logic [31:0]             fetch_instr;
   logic [EXCCODE_SIZE-1:0] fetch_exccode;
   fd_ctl_e                 fd_ctl;
   logic [31:0]             bubble_pc;

   assign imem_addr     = pc_q;
   assign fault         = fetch_fault(pc_q, IM_LO, IM_HI);
   assign fetch_instr   = fault ? 32'h0 : imem_rdata;
   assign fetch_exccode = fault ? EXCCODE_ADEL : EXCCODE_NONE;

   // A faulting pc still advances; the fault travels down as d_exccode only.
   always_comb begin
      pc_d      = pc_q;
      fd_ctl    = FdHold;
      bubble_pc = pc_q;
      if (req) begin
         pc_d      = HANDLER_PC;
         fd_ctl    = FdBubble;
         bubble_pc = HANDLER_PC;
      end else if (stall) begin
         pc_d   = pc_q;
         fd_ctl = FdHold;
      end else if (eret) begin
         pc_d   = epc;
         fd_ctl = FdBubble;
      end else if (npc_sel) begin
         pc_d   = npc_target;
         fd_ctl = FdLoad;
      end else begin
         pc_d   = pc_q + 32'd4;
         fd_ctl = FdLoad;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   fd_reg u_fd_reg (
      .clk          (clk),
      .reset        (reset),
      .ctl          (fd_ctl),
      .load_instr   (fetch_instr),
      .load_pc      (pc_q),
      .load_exccode (fetch_exccode),
      .load_bd      (d_is_branch),
      .bubble_pc    (bubble_pc),
      .d_instr      (d_instr),
      .d_pc         (d_pc),
      .d_exccode    (d_exccode),
      .d_bd         (d_bd)
   );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed scenarios plus randomized traffic against a reference model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset, stall, req, eret, npc_sel, d_is_branch;
   logic [31:0] epc, npc_target, imem_addr, imem_rdata, d_instr, d_pc;
   logic [4:0]  d_exccode;
   logic        d_bd;

   logic        use_fixed;
   logic [31:0] fixed_word;
   int          n_checks = 0;
   int          n_pass   = 0;

   // Reference model state
   logic [31:0] m_pc, m_instr, m_dpc;
   logic [4:0]  m_exc;
   logic        m_bd;

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
   endfunction

   assign imem_rdata = use_fixed ? fixed_word : mem_word(imem_addr);

   fetch_stage dut (
      .clk         (clk),
      .reset       (reset),
      .stall       (stall),
      .req         (req),
      .eret        (eret),
      .epc         (epc),
      .npc_sel     (npc_sel),
      .npc_target  (npc_target),
      .d_is_branch (d_is_branch),
      .imem_addr   (imem_addr),
      .imem_rdata  (imem_rdata),
      .d_instr     (d_instr),
      .d_pc        (d_pc),
      .d_exccode   (d_exccode),
      .d_bd        (d_bd)
   );

   // Advance the model by one edge from the current inputs, then let the DUT take the edge.
   task automatic step();
      logic [31:0] word;
      logic        bad;
      word = use_fixed ? fixed_word : mem_word(m_pc);
      bad  = (m_pc % 4 != 0) || (m_pc < 32'h3000) || (m_pc > 32'h6FFF);
      if (reset) begin
         m_pc = 32'h3000; m_instr = 0; m_dpc = 0; m_exc = 0; m_bd = 0;
      end else if (req) begin
         m_pc = 32'h4180; m_instr = 0; m_dpc = 32'h4180; m_exc = 0; m_bd = 0;
      end else if (stall) begin
         m_pc = m_pc;
      end else if (eret) begin
         m_instr = 0; m_dpc = m_pc; m_exc = 0; m_bd = 0;
         m_pc = epc;
      end else begin
         m_instr = bad ? 32'h0 : word;
         m_dpc   = m_pc;
         m_exc   = bad ? 5'd4 : 5'd0;
         m_bd    = d_is_branch;
         m_pc    = npc_sel ? npc_target : m_pc + 32'd4;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      reset = 0; stall = 0; req = 0; eret = 0; npc_sel = 0; d_is_branch = 0;
      epc = 0; npc_target = 0;
   endtask

   task automatic test_reset();
      clear_inputs();
      reset = 1;
      step();
      reset = 0;
      n_checks++; if (imem_addr !== 32'h3000) $display("FAIL reset_addr got %h want %h", imem_addr, 32'h3000); else n_pass++;
      n_checks++; if (d_instr !== 32'h0) $display("FAIL reset_instr got %h want 0", d_instr); else n_pass++;
      n_checks++; if (d_pc !== 32'h0) $display("FAIL reset_dpc got %h want 0", d_pc); else n_pass++;
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL reset_exc got %0d want 0", d_exccode); else n_pass++;
      n_checks++; if (d_bd !== 1'b0) $display("FAIL reset_bd got %b want 0", d_bd); else n_pass++;
   endtask

   task automatic test_free_run();
      logic [31:0] want;
      for (int i = 1; i <= 3; i++) begin
         step();
         want = 32'h3000 + 32'(4 * i);
         n_checks++; if (imem_addr !== want) $display("FAIL free_run_addr got %h want %h", imem_addr, want); else n_pass++;
      end
      n_checks++; if (d_pc !== 32'h3008) $display("FAIL free_run_dpc got %h want %h", d_pc, 32'h3008); else n_pass++;
      n_checks++; if (d_instr !== 32'h3402_0005) $display("FAIL free_run_instr got %h want %h", d_instr, 32'h3402_0005); else n_pass++;
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL free_run_exc got %0d want 0", d_exccode); else n_pass++;
      n_checks++; if (d_bd !== 1'b0) $display("FAIL free_run_bd got %b want 0", d_bd); else n_pass++;
   endtask

   task automatic test_stall();
      step();
      stall = 1;
      for (int i = 0; i < 2; i++) begin
         step();
         n_checks++; if (imem_addr !== 32'h3010) $display("FAIL stall_addr got %h want %h", imem_addr, 32'h3010); else n_pass++;
         n_checks++; if (d_pc !== 32'h300C) $display("FAIL stall_dpc got %h want %h", d_pc, 32'h300C); else n_pass++;
      end
      stall = 0;
      step();
      n_checks++; if (imem_addr !== 32'h3014) $display("FAIL stall_release got %h want %h", imem_addr, 32'h3014); else n_pass++;
      n_checks++; if (d_pc !== 32'h3010) $display("FAIL stall_release_dpc got %h want %h", d_pc, 32'h3010); else n_pass++;
   endtask

   task automatic test_branch();
      repeat (3) step();
      npc_sel = 1; d_is_branch = 1; npc_target = 32'h3100;
      step();
      npc_sel = 0; d_is_branch = 0;
      n_checks++; if (imem_addr !== 32'h3100) $display("FAIL branch_addr got %h want %h", imem_addr, 32'h3100); else n_pass++;
      n_checks++; if (d_pc !== 32'h3020) $display("FAIL branch_dpc got %h want %h", d_pc, 32'h3020); else n_pass++;
      n_checks++; if (d_bd !== 1'b1) $display("FAIL branch_bd got %b want 1", d_bd); else n_pass++;
      n_checks++; if (d_instr !== 32'h3402_0005) $display("FAIL branch_instr got %h want %h", d_instr, 32'h3402_0005); else n_pass++;
   endtask

   task automatic test_fetch_fault();
      npc_sel = 1; npc_target = 32'h3102;
      step();
      npc_sel = 0;
      step();
      n_checks++; if (d_exccode !== 5'd4) $display("FAIL misalign_exc got %0d want 4", d_exccode); else n_pass++;
      n_checks++; if (d_instr !== 32'h0) $display("FAIL misalign_instr got %h want 0", d_instr); else n_pass++;
      n_checks++; if (d_pc !== 32'h3102) $display("FAIL misalign_dpc got %h want %h", d_pc, 32'h3102); else n_pass++;
      npc_sel = 1; npc_target = 32'h6FFC;
      step();
      npc_sel = 0;
      step();
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL top_word_exc got %0d want 0", d_exccode); else n_pass++;
      step();
      n_checks++; if (d_pc !== 32'h7000) $display("FAIL range_dpc got %h want %h", d_pc, 32'h7000); else n_pass++;
      n_checks++; if (d_exccode !== 5'd4) $display("FAIL range_exc got %0d want 4", d_exccode); else n_pass++;
   endtask

   task automatic test_req_over_stall();
      npc_sel = 1; npc_target = 32'h3050;
      step();
      npc_sel = 0; req = 1; stall = 1;
      step();
      req = 0; stall = 0;
      n_checks++; if (imem_addr !== 32'h4180) $display("FAIL req_addr got %h want %h", imem_addr, 32'h4180); else n_pass++;
      n_checks++; if (d_instr !== 32'h0) $display("FAIL req_instr got %h want 0", d_instr); else n_pass++;
      n_checks++; if (d_pc !== 32'h4180) $display("FAIL req_dpc got %h want %h", d_pc, 32'h4180); else n_pass++;
      n_checks++; if (d_exccode !== 5'd0) $display("FAIL req_exc got %0d want 0", d_exccode); else n_pass++;
   endtask

   task automatic test_eret();
      repeat (4) step();
      eret = 1; epc = 32'h3024;
      step();
      eret = 0;
      n_checks++; if (imem_addr !== 32'h3024) $display("FAIL eret_addr got %h want %h", imem_addr, 32'h3024); else n_pass++;
      n_checks++; if (d_instr !== 32'h0) $display("FAIL eret_instr got %h want 0", d_instr); else n_pass++;
      n_checks++; if (d_pc !== 32'h4190) $display("FAIL eret_dpc got %h want %h", d_pc, 32'h4190); else n_pass++;
      step();
      n_checks++; if (d_pc !== 32'h3024) $display("FAIL eret_next_dpc got %h want %h", d_pc, 32'h3024); else n_pass++;
   endtask

   task automatic test_reset_mid_redirect();
      stall = 1; npc_sel = 1; npc_target = 32'h5000; reset = 1;
      step();
      clear_inputs();
      n_checks++; if (imem_addr !== 32'h3000) $display("FAIL midreset_addr got %h want %h", imem_addr, 32'h3000); else n_pass++;
      n_checks++; if (d_pc !== 32'h0) $display("FAIL midreset_dpc got %h want 0", d_pc); else n_pass++;
      n_checks++; if (d_instr !== 32'h0) $display("FAIL midreset_instr got %h want 0", d_instr); else n_pass++;
   endtask

   function automatic logic [31:0] rand_target();
      case ($urandom_range(0, 3))
         0:       return $urandom;
         1:       return 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'h3) + 32'($urandom_range(1, 3));
         default: return 32'h3000 + ($urandom_range(0, 32'h3FFF) & ~32'h3);
      endcase
   endfunction

   task automatic test_random();
      use_fixed = 0;
      clear_inputs();
      reset = 1;
      step();
      for (int i = 0; i < 400; i++) begin
         reset       = ($urandom_range(0, 59) == 0);
         req         = ($urandom_range(0, 19) == 0);
         stall       = ($urandom_range(0, 4) == 0);
         eret        = ($urandom_range(0, 9) == 0);
         npc_sel     = ($urandom_range(0, 3) == 0);
         d_is_branch = $urandom_range(0, 1);
         npc_target  = rand_target();
         epc         = rand_target();
         step();
         n_checks++; if (imem_addr !== m_pc) $display("FAIL rand_addr[%0d] got %h want %h", i, imem_addr, m_pc); else n_pass++;
         n_checks++; if (d_instr !== m_instr) $display("FAIL rand_instr[%0d] got %h want %h", i, d_instr, m_instr); else n_pass++;
         n_checks++; if (d_pc !== m_dpc) $display("FAIL rand_dpc[%0d] got %h want %h", i, d_pc, m_dpc); else n_pass++;
         n_checks++; if (d_exccode !== m_exc) $display("FAIL rand_exc[%0d] got %0d want %0d", i, d_exccode, m_exc); else n_pass++;
         n_checks++; if (d_bd !== m_bd) $display("FAIL rand_bd[%0d] got %b want %b", i, d_bd, m_bd); else n_pass++;
      end
      clear_inputs();
   endtask

   initial begin
      clear_inputs();
      use_fixed  = 1;
      fixed_word = 32'h3402_0005;
      m_pc = 0; m_instr = 0; m_dpc = 0; m_exc = 0; m_bd = 0;
      @(negedge clk);
      test_reset();
      test_free_run();
      test_stall();
      test_branch();
      test_fetch_fault();
      test_req_over_stall();
      test_eret();
      test_reset_mid_redirect();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
